// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and the
// baud divider calculation used by both the RX and TX controllers.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;

    // Integer-truncated sysclk cycles per oversample tick.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider: one-cycle tick every DIV clocks, with a
// synchronous clear so sampling can be re-aligned to a start edge.
module uart_baud_tick #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] Last = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == Last)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == Last) && !clr;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-FF synchroniser, 16x oversampling with 3-sample majority vote and a
// one-byte holding register with sticky flags. Define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx_ctrl #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       rx_parity_err,
`endif
    output logic       rx_busy
);

    import uart_pkg::*;

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam logic [3:0] SampleFirst  = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] SampleSecond = 4'(MID_SAMPLE);
    localparam logic [3:0] SampleDecide = 4'(MID_SAMPLE + 1);
    localparam logic [3:0] SampleLast   = 4'(OVERSAMPLE - 1);

    rx_state_e  state_q, state_d;
    logic [1:0] sync_q;
    logic       rxs, rxs_prev_q, fall, tick, tick_clr, decide, last, vote;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] bidx_q, bidx_d;
    logic [7:0] shreg_q, shreg_d;
    logic [1:0] votes_q, votes_d;
    logic       stop_ok, frame_evt, accept, overrun_evt;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic       drop_q, drop_d, par_evt, perr_q, perr_d;
`endif

    assign rxs      = sync_q[1];
    assign fall     = rxs_prev_q && !rxs;
    assign tick_clr = (state_q == StIdle) && fall;
    assign decide   = tick && (scnt_q == SampleDecide);
    assign last     = tick && (scnt_q == SampleLast);
    assign vote     = (votes_q[0] & votes_q[1]) | (votes_q[0] & rxs) | (votes_q[1] & rxs);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (sysclk),
        .rst_n (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        bidx_d    = bidx_q;
        shreg_d   = shreg_q;
        votes_d   = votes_q;
        stop_ok   = 1'b0;
        frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
        drop_d    = drop_q;
        par_evt   = 1'b0;
`endif
        if (tick) begin
            scnt_d = scnt_q + 4'd1;
        end
        if (tick && ((scnt_q == SampleFirst) || (scnt_q == SampleSecond))) begin
            votes_d = {votes_q[0], rxs};
        end
        unique case (state_q)
            StIdle: begin
                scnt_d = '0;
                bidx_d = '0;
`ifdef UART_RX_PARITY_EN
                drop_d = 1'b0;
`endif
                if (fall) state_d = StStart;
            end
            StStart: begin
                // A start bit that votes high was a glitch: drop back silently.
                if (decide && vote) begin
                    state_d = StIdle;
                    scnt_d  = '0;
                end else if (last) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (decide) shreg_d = {vote, shreg_q[7:1]};
                if (last) begin
                    bidx_d = bidx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bidx_q == 3'd7) state_d = StParity;
`else
                    if (bidx_q == 3'd7) state_d = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (decide && ((^shreg_q) ^ vote)) begin
                    par_evt = 1'b1;
                    drop_d  = 1'b1;
                end
                if (last) state_d = StStop;
            end
`endif
            StStop: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (decide) begin
                    scnt_d = '0;
                    if (vote) begin
`ifdef UART_RX_PARITY_EN
                        stop_ok = !drop_q;
`else
                        stop_ok = 1'b1;
`endif
                        state_d = StIdle;
                    end else begin
                        frame_evt = 1'b1;
                        state_d   = StBreak;
                    end
                end
            end
            StBreak: begin
                if (!rxs) begin
                    scnt_d = '0;
                end else if (last) begin
                    scnt_d  = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A read coinciding with acceptance counts as consuming the old byte.
    always_comb begin
        accept      = stop_ok && (!valid_q || rd_en);
        overrun_evt = stop_ok && valid_q && !rd_en;
        data_d      = accept ? shreg_q : data_q;
        valid_d     = accept || (valid_q && !rd_en);
        ovr_d       = overrun_evt || (ovr_q && !rd_en);
        ferr_d      = frame_evt || (ferr_q && !rd_en);
`ifdef UART_RX_PARITY_EN
        perr_d      = par_evt || (perr_q && !rd_en);
`endif
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
            state_q    <= StIdle;
            scnt_q     <= '0;
            bidx_q     <= '0;
            shreg_q    <= '0;
            votes_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            drop_q     <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[0], uart_rx};
            rxs_prev_q <= rxs;
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            bidx_q     <= bidx_d;
            shreg_q    <= shreg_d;
            votes_q    <= votes_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            drop_q     <= drop_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed vector table, hand-written corner sequences and a
// randomised frame stream scored against a byte-level holding-register model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int unsigned CLK_FREQ = 4800000;
    localparam int unsigned BAUD     = 100000;
    localparam int BIT_CYC = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_EXTRA = BIT_CYC;
`else
    localparam int FRAME_EXTRA = 0;
`endif
    // Stop decision lands about 9.56 bit times plus a few clocks after the start edge.
    localparam int LAT_MIN = (BIT_CYC * 956) / 100 - 12 + FRAME_EXTRA;
    localparam int LAT_MAX = (BIT_CYC * 956) / 100 + 18 + FRAME_EXTRA;

    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_overrun, rx_frame_err, rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int rise_cnt = 0;
    logic valid_prev = 1'b0;

    typedef struct {
        bit         rd_before;
        logic [7:0] data;
        bit         stop_good;
        logic [7:0] exp_data;
        logic       exp_v;
        logic       exp_o;
        logic       exp_f;
    } vec_t;
    vec_t vecs[8];

    uart_rx_ctrl #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .sysclk        (sysclk),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .rd_en         (rd_en),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_overrun    (rx_overrun),
        .rx_frame_err  (rx_frame_err),
`ifdef UART_RX_PARITY_EN
        .rx_parity_err (rx_parity_err),
`endif
        .rx_busy       (rx_busy)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (rx_valid && !valid_prev) begin
            rise_cyc = cyc;
            rise_cnt++;
        end
        valid_prev = rx_valid;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic check_outputs(input string name, input logic [7:0] d, input logic v,
                                 input logic o, input logic f, input logic p);
        check({name, "_data"}, 32'(rx_data), 32'(d));
        check({name, "_valid"}, 32'(rx_valid), 32'(v));
        check({name, "_overrun"}, 32'(rx_overrun), 32'(o));
        check({name, "_frame_err"}, 32'(rx_frame_err), 32'(f));
        check({name, "_busy"}, 32'(rx_busy), 32'd0);
`ifdef UART_RX_PARITY_EN
        check({name, "_parity_err"}, 32'(rx_parity_err), 32'(p));
`else
        if (p) $display("note: parity expectation ignored in 8N1 build");
`endif
    endtask

    task automatic line_hold(input logic v, input int n);
        @(negedge sysclk);
        uart_rx = v;
        repeat (n - 1) @(negedge sysclk);
    endtask

    // Start bit, 8 data bits LSB-first and (in 8E1 builds) the parity bit.
    task automatic send_body(input logic [7:0] b, input bit par_bad);
        @(negedge sysclk);
        uart_rx   = 1'b0;
        start_cyc = cyc;
        repeat (BIT_CYC - 1) @(negedge sysclk);
        for (int i = 0; i < 8; i++) line_hold(b[i], BIT_CYC);
`ifdef UART_RX_PARITY_EN
        line_hold((^b) ^ par_bad, BIT_CYC);
`else
        if (par_bad) $display("note: parity error request ignored in 8N1 build");
`endif
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_good, input bit par_bad);
        send_body(b, par_bad);
        if (stop_good) begin
            line_hold(1'b1, BIT_CYC);
        end else begin
            line_hold(1'b0, 2 * BIT_CYC);
            line_hold(1'b1, 2 * BIT_CYC);
        end
    endtask

    task automatic do_read();
        @(negedge sysclk);
        rd_en = 1'b1;
        @(negedge sysclk);
        rd_en = 1'b0;
    endtask

    initial begin
        int lat;
        int rc0;
        logic [7:0] m_d;
        logic m_v, m_o, m_f, m_p;

        vecs[0] = '{0, 8'h44, 1, 8'h44, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1, 8'h11, 1, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{0, 8'h22, 1, 8'h11, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1, 8'hA5, 0, 8'h11, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{0, 8'h3C, 1, 8'h3C, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1, 8'h00, 1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1, 8'hFF, 1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{0, 8'h81, 0, 8'hFF, 1'b1, 1'b0, 1'b1};

        repeat (4) @(negedge sysclk);
        check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        line_hold(1'b1, BIT_CYC);

        // Single byte with latency measurement.
        rc0 = rise_cnt;
        send_frame(8'h44, 1, 0);
        lat = rise_cyc - start_cyc;
        check("latency_window", 32'((rise_cnt == rc0 + 1) && lat >= LAT_MIN && lat <= LAT_MAX),
              32'd1);
        check_outputs("single", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
        do_read();
        check("single_read_valid", 32'(rx_valid), 32'd0);
        check("single_read_data", 32'(rx_data), 32'h44);

        // Short low glitch on an idle line.
        @(negedge sysclk);
        uart_rx = 1'b0;
        repeat (6) @(negedge sysclk);
        check("glitch_busy", 32'(rx_busy), 32'd1);
        repeat (6) @(negedge sysclk);
        uart_rx = 1'b1;
        repeat (BIT_CYC) @(negedge sysclk);
        check_outputs("glitch", 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1, 0);
        check_outputs("after_glitch", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        do_read();

        // Read strobe landing on the acceptance cycle of a second byte.
        rc0 = rise_cnt;
        send_frame(8'h11, 1, 0);
        lat = rise_cyc - start_cyc;
        check("simul_first_rise", 32'(rise_cnt), 32'(rc0 + 1));
        fork
            send_frame(8'h22, 1, 0);
            begin
                repeat (4) @(negedge sysclk);
                for (int k = 0; k < 20 * BIT_CYC && cyc != start_cyc + lat - 1; k++)
                    @(negedge sysclk);
                rd_en = 1'b1;
                @(negedge sysclk);
                rd_en = 1'b0;
            end
        join
        check_outputs("simul_read", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        do_read();

        // Stop bit held low for two bits, then the line recovers.
        send_body(8'hA5, 0);
        line_hold(1'b0, BIT_CYC);
        check("ferr_flag", 32'(rx_frame_err), 32'd1);
        check("ferr_valid", 32'(rx_valid), 32'd0);
        line_hold(1'b0, BIT_CYC);
        check("ferr_break_busy", 32'(rx_busy), 32'd1);
        line_hold(1'b1, 2 * BIT_CYC);
        check_outputs("ferr_recover", 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 1, 0);
        check_outputs("ferr_next", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        do_read();
        check("ferr_cleared", 32'(rx_frame_err), 32'd0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rd_before) do_read();
            send_frame(vecs[i].data, vecs[i].stop_good, 0);
            check_outputs($sformatf("tbl%0d", i), vecs[i].exp_data, vecs[i].exp_v,
                          vecs[i].exp_o, vecs[i].exp_f, 1'b0);
        end

        // Reset during data bit 4 of 0xFF.
        fork
            send_frame(8'hFF, 1, 0);
            begin
                repeat (5 * BIT_CYC + BIT_CYC / 2) @(negedge sysclk);
                check("midrst_busy_before", 32'(rx_busy), 32'd1);
                reset = 1'b0;
                #1;
                check("midrst_data", 32'(rx_data), 32'h00);
                check("midrst_valid", 32'(rx_valid), 32'd0);
                check("midrst_frame_err", 32'(rx_frame_err), 32'd0);
                check("midrst_busy", 32'(rx_busy), 32'd0);
                repeat (3) @(negedge sysclk);
                reset = 1'b1;
            end
        join
        line_hold(1'b1, BIT_CYC);
        send_frame(8'h81, 1, 0);
        check_outputs("midrst_next", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        do_read();

        // Random frames against a byte-level model of the holding register.
        m_d = 8'h81;
        m_v = 1'b0;
        m_o = 1'b0;
        m_f = 1'b0;
        m_p = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            bit rd_b, stop_g, par_b;
            b      = 8'($urandom_range(0, 255));
            rd_b   = ($urandom_range(0, 1) == 1);
            stop_g = ($urandom_range(0, 6) != 0);
`ifdef UART_RX_PARITY_EN
            par_b  = ($urandom_range(0, 7) == 0);
`else
            par_b  = 1'b0;
`endif
            if (rd_b) begin
                do_read();
                m_v = 1'b0;
                m_o = 1'b0;
                m_f = 1'b0;
                m_p = 1'b0;
            end
            send_frame(b, stop_g, par_b);
            if (par_b) m_p = 1'b1;
            if (!stop_g) begin
                m_f = 1'b1;
            end else if (!par_b) begin
                if (m_v) m_o = 1'b1;
                else begin
                    m_d = b;
                    m_v = 1'b1;
                end
            end
            check_outputs($sformatf("rnd%0d", i), m_d, m_v, m_o, m_f, m_p);
            line_hold(1'b1, $urandom_range(1, 30));
        end

`ifdef UART_RX_PARITY_EN
        do_read();
        send_frame(8'h03, 1, 0);
        check_outputs("par_good", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        do_read();
        send_frame(8'h03, 1, 1);
        check_outputs("par_bad", 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
        do_read();
        check("par_cleared", 32'(rx_parity_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
